// File: rtl/lut_loader_pkg.sv
// Shared LUT geometry and the k -> (bank, addr) mapping used by both the
// loader and the read-side address calculation.
package lut_loader_pkg;

    localparam int I_SIZE          = 0;
    localparam int J_SIZE          = 2;
    localparam int X_ENC_SIZE      = 3;
    localparam int BRAM_COUNT_SIZE = 1;
    localparam int BRAM_COUNT      = 2 ** BRAM_COUNT_SIZE;
    localparam int K_SIZE          = I_SIZE + J_SIZE + X_ENC_SIZE;
    localparam int ADDR_SIZE       = K_SIZE - BRAM_COUNT_SIZE;
    localparam int RAM_WIDTH       = 8;

    // Loader FSM encoding
    localparam logic [1:0] LUT_IDLE  = 2'd0;
    localparam logic [1:0] LUT_LOAD  = 2'd1;
    localparam logic [1:0] LUT_FLUSH = 2'd2;

    typedef struct packed {
        logic [ADDR_SIZE-1:0]       addr;
        logic [BRAM_COUNT_SIZE-1:0] bank;
    } lut_loc_t;

    // Low bits of k pick the bank so consecutive j/x entries land in
    // different banks; the remaining high bits form the per-bank address.
    function automatic lut_loc_t lut_split(input logic [K_SIZE-1:0] k);
        lut_loc_t loc;
        loc.bank = k[BRAM_COUNT_SIZE-1:0];
        loc.addr = k[K_SIZE-1:BRAM_COUNT_SIZE];
        return loc;
    endfunction

endpackage

// File: rtl/lut_index_split.sv
// Combinational split of a flat LUT index into a one-hot bank select and a
// per-bank address, shared with the read-side address calculation.
module lut_index_split
    import lut_loader_pkg::*;
#(
    parameter int K_SIZE          = lut_loader_pkg::K_SIZE,
    parameter int BRAM_COUNT_SIZE = lut_loader_pkg::BRAM_COUNT_SIZE,
    parameter int BRAM_COUNT      = 2 ** BRAM_COUNT_SIZE,
    parameter int ADDR_SIZE       = K_SIZE - BRAM_COUNT_SIZE
) (
    input  logic [K_SIZE-1:0]     k,
    output logic [BRAM_COUNT-1:0] bank_sel,
    output logic [ADDR_SIZE-1:0]  addr
);

    logic [BRAM_COUNT_SIZE-1:0] bank;

    assign bank = k[BRAM_COUNT_SIZE-1:0];
    assign addr = k[K_SIZE-1:BRAM_COUNT_SIZE];

    // Decode the bank number into exactly one enable bit
    always_comb begin
        bank_sel       = '0;
        bank_sel[bank] = 1'b1;
    end

endmodule

// File: rtl/lut_loader.sv
// Writer side of the LUT BRAM banks: takes LUT bytes in canonical k order
// over valid/ready, scatters each to its bank/address and raises lut_ready
// once the whole table has been written.
module lut_loader
    import lut_loader_pkg::*;
#(
    parameter int I_SIZE          = lut_loader_pkg::I_SIZE,
    parameter int J_SIZE          = lut_loader_pkg::J_SIZE,
    parameter int X_ENC_SIZE      = lut_loader_pkg::X_ENC_SIZE,
    parameter int BRAM_COUNT_SIZE = lut_loader_pkg::BRAM_COUNT_SIZE,
    parameter int BRAM_COUNT      = 2 ** BRAM_COUNT_SIZE,
    parameter int K_SIZE          = I_SIZE + J_SIZE + X_ENC_SIZE,
    parameter int ADDR_SIZE       = K_SIZE - BRAM_COUNT_SIZE,
    parameter int RAM_WIDTH       = lut_loader_pkg::RAM_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [RAM_WIDTH-1:0]  in_data,
    output logic                  in_ready,
    output logic [BRAM_COUNT-1:0] wr_en,
    output logic [ADDR_SIZE-1:0]  wr_addr,
    output logic [RAM_WIDTH-1:0]  wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  lut_ready
);

    logic [1:0]            state;
    logic [K_SIZE-1:0]     k;
    logic [BRAM_COUNT-1:0] k_sel;
    logic [ADDR_SIZE-1:0]  k_addr;
    logic                  fire;
    logic                  k_last;

    lut_index_split #(
        .K_SIZE          (K_SIZE),
        .BRAM_COUNT_SIZE (BRAM_COUNT_SIZE),
        .BRAM_COUNT      (BRAM_COUNT),
        .ADDR_SIZE       (ADDR_SIZE)
    ) u_split (
        .k        (k),
        .bank_sel (k_sel),
        .addr     (k_addr)
    );

    // Ready only while loading, so bytes offered in IDLE/FLUSH stay unconsumed
    assign in_ready = (state == LUT_LOAD);
    assign fire     = in_valid && in_ready;
    // Terminal index is all-ones; k never relies on wrapping to 0
    assign k_last   = &k;

    // Load sequencing and the registered write port (one strobe per accepted byte)
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= LUT_IDLE;
            k         <= '0;
            wr_en     <= '0;
            wr_addr   <= '0;
            wr_data   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            lut_ready <= 1'b0;
        end else begin
            case (state)
                LUT_IDLE: begin
                    wr_en <= '0;
                    done  <= 1'b0;
                    if (start) begin
                        state     <= LUT_LOAD;
                        k         <= '0;
                        lut_ready <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                LUT_LOAD: begin
                    done <= 1'b0;
                    if (fire) begin
                        wr_en   <= k_sel;
                        wr_addr <= k_addr;
                        wr_data <= in_data;
                        if (k_last) begin
                            state <= LUT_FLUSH;
                        end else begin
                            k <= k + K_SIZE'(1);
                        end
                    end else begin
                        wr_en <= '0;
                    end
                end
                LUT_FLUSH: begin
                    // Last write is on the bus now; the table is complete after this edge
                    wr_en     <= '0;
                    done      <= 1'b1;
                    lut_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= LUT_IDLE;
                end
                default: begin
                    wr_en <= '0;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= LUT_IDLE;
                end
            endcase
        end
    end

endmodule
